// File: rtl/pipeif_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: PC source codes,
// fetch FSM encodings and the default bubble instruction.
package pipeif_fetch_pkg;

    localparam int DATA_LEN = 32;

    // pcsource codes driven by decode
    localparam logic [1:0] PCSRC_PC4 = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    // sll $0,$0,0
    localparam logic [DATA_LEN-1:0] NOP_INST_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_IDLE = 2'b00,
        IF_WAIT = 2'b01,
        IF_HOLD = 2'b10
    } if_state_t;

    // Sequential PC step; wraps modulo 2^32.
    function automatic logic [DATA_LEN-1:0] pc_plus4(input logic [DATA_LEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pipeif_fetch_if.sv
// Instruction memory port: one outstanding request, variable read latency.
interface pipeif_fetch_if;
    import pipeif_fetch_pkg::*;

    logic                req;
    logic [DATA_LEN-1:0] addr;
    logic                gnt;
    logic                rvalid;
    logic [DATA_LEN-1:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/pipeif_fetch_mux4.sv
// Four-way redirect target selector indexed by pcsource.
module pipeif_fetch_mux4
    import pipeif_fetch_pkg::*;
#(
    parameter int W = DATA_LEN
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    input  logic [1:0]   sel,
    output logic [W-1:0] y
);

    // Pure combinational select
    always_comb begin
        y = in0;
        case (sel)
            PCSRC_PC4: y = in0;
            PCSRC_BR:  y = in1;
            PCSRC_JR:  y = in2;
            PCSRC_J:   y = in3;
            default:   y = in0;
        endcase
    end

endmodule

// File: rtl/pipeif_fetch.sv
// Instruction fetch stage and IF/ID pipeline register. Keeps one request in
// flight, parks a returned word in a one-entry buffer during load-use stalls,
// and honours the single branch delay slot when decode redirects the PC.
module pipeif_fetch
    import pipeif_fetch_pkg::*;
#(
    parameter logic [DATA_LEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [DATA_LEN-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DATA_LEN-1:0] bpc,
    input  logic [DATA_LEN-1:0] rpc,
    input  logic [DATA_LEN-1:0] jpc,
    input  logic [1:0]          pcsource,
    input  logic                wpcir,
    pipeif_fetch_if.master      imem,
    output logic [DATA_LEN-1:0] dpc4,
    output logic [DATA_LEN-1:0] inst,
    output logic                dvalid
);

    if_state_t           state;
    logic [DATA_LEN-1:0] pc;
    logic [DATA_LEN-1:0] pc4;
    logic [DATA_LEN-1:0] buf_word;
    logic [DATA_LEN-1:0] redir_tgt;
    logic                redir_pend;
    logic [DATA_LEN-1:0] target;
    logic [DATA_LEN-1:0] next_pc;
    logic [DATA_LEN-1:0] word;
    logic                deliver;
    logic                redirect;

    assign pc4 = pc_plus4(pc);

    pipeif_fetch_mux4 #(.W(DATA_LEN)) u_tgt_mux (
        .in0 (pc4),
        .in1 (bpc),
        .in2 (rpc),
        .in3 (jpc),
        .sel (pcsource),
        .y   (target)
    );

    // A word is handed to decode when one is available and decode is not stalled
    always_comb begin
        deliver = 1'b0;
        word    = buf_word;
        case (state)
            IF_WAIT: begin
                deliver = imem.rvalid & wpcir;
                word    = imem.rdata;
            end
            IF_HOLD: deliver = wpcir;
            default: deliver = 1'b0;
        endcase
    end

    // The branch in ID redirects only when it is real and advancing
    assign redirect = dvalid & wpcir & (pcsource != PCSRC_PC4);

    // Same-cycle redirect wins; a parked target applies at the delay-slot delivery
    always_comb begin
        next_pc = pc4;
        if (redirect)
            next_pc = target;
        else if (redir_pend)
            next_pc = redir_tgt;
    end

    // New fetch from IDLE, or back-to-back with the delivery that frees the slot
    assign imem.req  = deliver | ((state == IF_IDLE) & wpcir);
    assign imem.addr = deliver ? next_pc : pc;

    // Fetch FSM: track the outstanding request and the stall buffer
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IF_IDLE;
            buf_word <= '0;
        end else begin
            case (state)
                IF_IDLE: begin
                    if (imem.req & imem.gnt)
                        state <= IF_WAIT;
                end
                IF_WAIT: begin
                    if (imem.rvalid) begin
                        if (wpcir) begin
                            state <= imem.gnt ? IF_WAIT : IF_IDLE;
                        end else begin
                            buf_word <= imem.rdata;
                            state    <= IF_HOLD;
                        end
                    end
                end
                IF_HOLD: begin
                    if (wpcir)
                        state <= imem.gnt ? IF_WAIT : IF_IDLE;
                end
                default: state <= IF_IDLE;
            endcase
        end
    end

    // IF/ID register and PC: load on delivery, bubble when advancing empty-handed
    always_ff @(posedge clock) begin
        if (reset) begin
            pc     <= RESET_PC;
            dpc4   <= '0;
            inst   <= NOP_INST;
            dvalid <= 1'b0;
        end else if (deliver) begin
            pc     <= next_pc;
            dpc4   <= pc4;
            inst   <= word;
            dvalid <= 1'b1;
        end else if (wpcir) begin
            inst   <= NOP_INST;
            dvalid <= 1'b0;
        end
    end

    // Remember a redirect whose delay slot has not been delivered yet
    always_ff @(posedge clock) begin
        if (reset) begin
            redir_pend <= 1'b0;
            redir_tgt  <= '0;
        end else if (redirect & ~deliver) begin
            redir_pend <= 1'b1;
            redir_tgt  <= target;
        end else if (deliver) begin
            redir_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipeif_fetch.sv
// Bench for pipeif_fetch: the bench acts as the instruction memory and keeps a
// program-order model of which address must reach decode next.
module tb_pipeif_fetch;
    import pipeif_fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] bpc = '0, rpc = '0, jpc = '0;
    logic [1:0]  pcsource = 2'b00;
    logic        wpcir = 1'b1;
    logic [31:0] dpc4, inst;
    logic        dvalid;

    pipeif_fetch_if bus ();

    pipeif_fetch #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clock    (clock),
        .reset    (reset),
        .bpc      (bpc),
        .rpc      (rpc),
        .jpc      (jpc),
        .pcsource (pcsource),
        .wpcir    (wpcir),
        .imem     (bus),
        .dpc4     (dpc4),
        .inst     (inst),
        .dvalid   (dvalid)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Program-order model state
    logic [31:0] m_pc, m_dpc4, m_inst, m_ptgt, m_addr;
    logic        m_dvalid, m_pend, m_out, m_have;
    int          cyc = 0;
    int          m_due = 0;
    logic        last_req;
    logic [31:0] last_addr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'hC000_0000 | a;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_dpc4 = '0; m_inst = NOP; m_dvalid = 1'b0;
        m_pend = 1'b0; m_ptgt = '0; m_out = 1'b0; m_have = 1'b0; m_addr = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; wpcir = 1'b1; pcsource = 2'b00;
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic after_edge();
        @(posedge clock);
        #1;
    endtask

    // One clock cycle: check IF/ID, drive decode + memory, check request, advance model
    task automatic step(input logic w, input logic [1:0] ps, input logic [31:0] b,
                        input logic [31:0] r, input logic [31:0] j, input logic g,
                        input int lat, input logic spur);
        logic        rv, deliver, redir, exp_req;
        logic [31:0] tgt, nxt, exp_addr;
        @(negedge clock);
        checks++;
        if (dpc4 !== m_dpc4 || inst !== m_inst || dvalid !== m_dvalid) begin
            errors++;
            $display("FAIL ifid cyc %0d got dpc4=%h inst=%h dvalid=%b want dpc4=%h inst=%h dvalid=%b",
                     cyc, dpc4, inst, dvalid, m_dpc4, m_inst, m_dvalid);
        end
        wpcir = w; pcsource = ps; bpc = b; rpc = r; jpc = j; bus.gnt = g;
        rv = m_out && (cyc == m_due);
        if (rv) begin
            bus.rvalid = 1'b1; bus.rdata = memf(m_addr);
        end else if (spur && !m_out) begin
            bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_BEEF;
        end else begin
            bus.rvalid = 1'b0; bus.rdata = $urandom;
        end
        #1;
        deliver = w && (rv || m_have);
        redir   = m_dvalid && w && (ps != 2'b00);
        tgt     = (ps == 2'b01) ? b : (ps == 2'b10) ? r : j;
        assert (!(redir && m_pend)) else $error("bench drove a redirect while one is pending");
        nxt      = redir ? tgt : (m_pend ? m_ptgt : m_pc + 32'd4);
        exp_req  = w && (deliver || (!m_out && !m_have));
        exp_addr = deliver ? nxt : m_pc;
        last_req = bus.req; last_addr = bus.addr;
        checks++;
        if (bus.req !== exp_req) begin
            errors++;
            $display("FAIL imem_req cyc %0d got %b want %b", cyc, bus.req, exp_req);
        end
        if (exp_req) begin
            checks++;
            if (bus.addr !== exp_addr) begin
                errors++;
                $display("FAIL imem_addr cyc %0d got %h want %h", cyc, bus.addr, exp_addr);
            end
        end
        if (deliver) begin
            m_dpc4 = m_pc + 32'd4; m_inst = memf(m_pc); m_dvalid = 1'b1;
            m_pc = nxt; m_pend = 1'b0;
        end else begin
            if (redir) begin m_pend = 1'b1; m_ptgt = tgt; end
            if (w) begin m_inst = NOP; m_dvalid = 1'b0; end
        end
        if (rv) begin
            m_out = 1'b0;
            if (!w) m_have = 1'b1;
        end
        if (deliver) m_have = 1'b0;
        if (exp_req && g) begin
            m_out = 1'b1; m_addr = exp_addr; m_due = cyc + lat;
        end
        cyc++;
    endtask

    task automatic run(input int n, input int lat);
        for (int i = 0; i < n; i++) step(1'b1, 2'b00, '0, '0, '0, 1'b1, lat, 1'b0);
    endtask

    initial begin
        logic [31:0] rb, rr, rj;
        logic [1:0]  rps;
        model_reset();

        // 1: single-cycle memory streams one instruction per cycle
        do_reset();
        chk("rst_dpc4", dpc4, 32'h0);
        chk("rst_inst", inst, NOP);
        chk("rst_dvalid", {31'b0, dvalid}, 32'h0);
        chk("rst_req", {31'b0, bus.req}, 32'h1);
        chk("rst_addr", bus.addr, RST_PC);
        run(2, 1); after_edge();
        chk("t1_dpc4_a", dpc4, 32'h4);
        chk("t1_inst_a", inst, 32'hC000_0000);
        chk("t1_dvalid_a", {31'b0, dvalid}, 32'h1);
        run(1, 1); after_edge();
        chk("t1_dpc4_b", dpc4, 32'h8);
        chk("t1_inst_b", inst, 32'hC000_0004);
        run(1, 1); after_edge();
        chk("t1_dpc4_c", dpc4, 32'hC);
        chk("t1_inst_c", inst, 32'hC000_0008);

        // 2: latency 3 leaves two bubbles between instructions
        do_reset();
        run(4, 3); after_edge();
        chk("t2_inst_a", inst, 32'hC000_0000);
        run(1, 3); after_edge();
        chk("t2_bubble_dvalid", {31'b0, dvalid}, 32'h0);
        chk("t2_bubble_inst", inst, NOP);
        chk("t2_bubble_dpc4", dpc4, 32'h4);
        run(2, 3); after_edge();
        chk("t2_dpc4_b", dpc4, 32'h8);

        // 3: load-use stall while the word returns
        do_reset();
        run(1, 1);
        step(1'b0, 2'b00, '0, '0, '0, 1'b1, 1, 1'b0);
        chk("t3_req_stall1", {31'b0, last_req}, 32'h0);
        step(1'b0, 2'b00, '0, '0, '0, 1'b1, 1, 1'b0);
        chk("t3_req_stall2", {31'b0, last_req}, 32'h0);
        after_edge();
        chk("t3_dvalid_held", {31'b0, dvalid}, 32'h0);
        step(1'b1, 2'b00, '0, '0, '0, 1'b1, 1, 1'b0);
        chk("t3_addr_resume", last_addr, 32'h4);
        after_edge();
        chk("t3_inst", inst, 32'hC000_0000);
        chk("t3_dpc4", dpc4, 32'h4);

        // 4: beq at 0x10 with the slot word already returning
        do_reset();
        run(6, 1);
        step(1'b1, 2'b01, 32'h40, '0, '0, 1'b1, 1, 1'b0);
        chk("t4_fetch_tgt", last_addr, 32'h40);
        after_edge();
        chk("t4_slot_dpc4", dpc4, 32'h18);
        chk("t4_slot_inst", inst, 32'hC000_0014);
        run(1, 1); after_edge();
        chk("t4_tgt_inst", inst, 32'hC000_0040);

        // 5: jr while the slot fetch is still in flight
        do_reset();
        run(16, 3);
        step(1'b1, 2'b10, '0, 32'h100, '0, 1'b1, 3, 1'b0);
        run(2, 3);
        chk("t5_fetch_tgt", last_addr, 32'h100);
        after_edge();
        chk("t5_slot_dpc4", dpc4, 32'h18);
        run(3, 3); after_edge();
        chk("t5_tgt_inst", inst, 32'hC000_0100);
        chk("t5_tgt_dpc4", dpc4, 32'h104);

        // 6: reset in WAIT, stale rvalid right after release
        do_reset();
        run(7, 3);
        do_reset();
        step(1'b1, 2'b00, '0, '0, '0, 1'b1, 1, 1'b1);
        run(1, 1); after_edge();
        chk("t6_inst", inst, 32'hC000_0000);
        chk("t6_dpc4", dpc4, 32'h4);

        // Randomised traffic: stalls, grant gaps, latency 1..4, redirects, wrap targets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rb = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            rr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : {$urandom_range(0, 255), 2'b00};
            rj = {$urandom_range(0, 1023), 2'b00};
            rps = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3) & {2{~m_dvalid}});
            step($urandom_range(0, 9) < 8, rps, rb, rr, rj, $urandom_range(0, 9) < 7,
                 $urandom_range(1, 4), $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
